// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - song RAM write port, playback control and note outputs
interface melody_sequencer_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic [AW-1:0] last_addr;
  logic          loop;
  logic          start;
  logic          stop;
  logic [15:0]   note;
  logic          playing;
  logic [AW-1:0] cur_addr;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, last_addr, loop, start, stop,
    input  note, playing, cur_addr, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, last_addr, loop, start, stop,
    output note, playing, cur_addr, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps through a song RAM of {rest, pitch, beats} entries
// and drives a one-hot note select with a silent gap after every entry.
module melody_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int AW          = 5
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, SOUND, GAP} state_t;

  localparam logic [31:0] BEAT_LEN = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAP_LEN  = 32'(GAP_CYCLES);

  logic [8:0]    mem [2**AW];
  state_t        state, state_next;
  logic [31:0]   cnt, cnt_next;
  logic [AW-1:0] addr, addr_next;
  logic [15:0]   note, note_next;
  logic          done, done_next;
  logic [8:0]    word;
  logic          last_entry;
  logic          cnt_zero;

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Read is only consumed on the FETCH->SOUND edge, so the word lands in registers.
  assign word       = mem[addr];
  assign last_entry = (addr == bus.last_addr);
  assign cnt_zero   = (cnt == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      note  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      addr  <= addr_next;
      note  <= note_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr;
    if (bus.stop) begin
      state_next = IDLE;
    end else if (bus.start) begin
      state_next = FETCH;
      addr_next  = '0;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        FETCH: begin
          // Sound plus gap fills whole beats; the extra FETCH cycle sits outside.
          state_next = SOUND;
          cnt_next   = (32'(word[3:0]) + 32'd1) * BEAT_LEN - GAP_LEN - 32'd1;
        end
        SOUND: begin
          if (cnt_zero) begin
            state_next = GAP;
            cnt_next   = GAP_LEN - 32'd1;
          end else begin
            cnt_next = cnt - 32'd1;
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt_next = cnt - 32'd1;
          end else if (!last_entry) begin
            state_next = FETCH;
            addr_next  = addr + 1'b1;
          end else if (bus.loop) begin
            state_next = FETCH;
            addr_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    note_next = '0;
    done_next = 1'b0;
    if (!bus.stop && !bus.start) begin
      if (state == FETCH)
        note_next = word[8] ? 16'h0000 : (16'h0001 << word[7:4]);
      else if (state == SOUND && !cnt_zero)
        note_next = note;
      if (state == GAP && cnt_zero && last_entry && !bus.loop)
        done_next = 1'b1;
    end
  end

  assign bus.note     = note;
  assign bus.playing  = (state != IDLE);
  assign bus.cur_addr = addr;
  assign bus.done     = done;
endmodule
